seq_divider: RTL

Multi-cycle unsigned restoring divider built on the team's add/subtract datapath. It takes an N-bit dividend and an N-bit divisor and returns quotient and remainder after N iteration cycles. It sits beside `addsub` in the arithmetic library: the inverse operation, realized as repeated subtract-and-restore. A start/busy/done handshake lets a controller or FSM sequence it.

---
 rtl/seq_divider.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider with start/busy/done handshake
// One quotient bit per cycle; a zero divisor skips the iterations and reports div_by_zero.
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_by_zero_o
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q;
  logic [N:0]    r_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  quot_q;
  logic [N-1:0]  rem_q;
  logic          dbz_q;

  logic [N:0]    r_shift;
  logic [N+1:0]  sub;
  logic [N:0]    r_d;
  logic [N-1:0]  q_d;
  logic          unused_r_msb;

  // The partial remainder never exceeds the divisor after a step, so its top bit is not needed by the shift.
  assign unused_r_msb = r_q[N];

  always_comb begin
    r_shift = {r_q[N-1:0], q_q[N-1]};
    sub     = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + (N+2)'(1);
    r_d     = r_shift;
    q_d     = {q_q[N-2:0], 1'b0};
    if (sub[N+1]) begin
      r_d = sub[N:0];
      q_d = {q_q[N-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            r_q     <= '0;
            q_q     <= dividend_i;
            d_q     <= divisor_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (d_q == '0) begin
            // Zero divisor: single pass through RUN, q_q still holds the dividend.
            quot_q  <= '1;
            rem_q   <= q_q;
            dbz_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
              quot_q  <= q_d;
              rem_q   <= r_d[N-1:0];
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule
